frame_buffer_scheduler: RTL and testbench

Triple-buffer scheduler for the DDR frame store shared by the camera write path (AXI4_writer) and the HDMI read path (AXI4_reader). It owns three frame buffers in PS DDR and hands each path a base address. The writer never writes the buffer being scanned out, and the reader always starts a frame on the newest complete image. It sits in the clk_100Mhz domain between the frame-event synchronizers and the two AXI masters' address generators.

---
 rtl/fb_pkg.sv | 11 +
 rtl/frame_buffer_scheduler_sat_counter.sv | 23 ++
 rtl/frame_buffer_scheduler.sv | 109 ++++++++++
 tb/tb_frame_buffer_scheduler.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared frame-store constants and index type. The AXI writer/reader address
// counters use the same constants, so the three buffers line up across blocks.
package fb_pkg;

    localparam int          FB_NUM          = 3;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'h1000_0000;
    localparam logic [31:0] DEF_FRAME_BYTES = 32'h0009_6000;

    typedef logic [1:0] fb_idx_t;

endpackage

// File: rtl/frame_buffer_scheduler_sat_counter.sv
// Saturating event counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             i_clr_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Triple-buffer scheduler: rotates writer/ready/reader buffer indices on frame
// events so the writer never touches the scanned-out buffer.
module frame_buffer_scheduler
    import fb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter logic [31:0] FRAME_BYTES = DEF_FRAME_BYTES,
    parameter int          CNT_W       = 16
) (
    input  logic             clk_100Mhz,
    input  logic             sys_rst_n,
    input  logic             wr_frame_done,
    input  logic             rd_frame_start,
    input  logic             freeze,
    output logic [31:0]      wr_base_addr,
    output logic [31:0]      rd_base_addr,
    output logic             rd_frame_valid,
    output logic [CNT_W-1:0] frames_dropped,
    output logic [CNT_W-1:0] frames_repeated
);

    localparam logic [31:0] ADDR0 = BASE_ADDR;
    localparam logic [31:0] ADDR1 = BASE_ADDR + FRAME_BYTES;
    localparam logic [31:0] ADDR2 = BASE_ADDR + FRAME_BYTES + FRAME_BYTES;

    function automatic logic [31:0] addr_of(input fb_idx_t idx);
        case (idx)
            2'd1:    addr_of = ADDR1;
            2'd2:    addr_of = ADDR2;
            default: addr_of = ADDR0;
        endcase
    endfunction

    fb_idx_t     r_wr_idx, r_rdy_idx, r_rd_idx;
    logic        r_fresh, r_has_frame, r_rd_valid;
    logic [31:0] r_wr_base, r_rd_base;

    fb_idx_t w_wr_n, w_rdy_mid, w_rdy_n, w_rd_n;
    logic    w_fresh_mid, w_fresh_n, w_has_frame_n, w_take, w_drop_inc, w_rep_inc;

    // Write swap is resolved first; the read swap then sees the post-write
    // state, so a simultaneous read start picks up the frame just completed.
    always_comb begin
        w_wr_n        = r_wr_idx;
        w_rdy_mid     = r_rdy_idx;
        w_fresh_mid   = r_fresh;
        w_has_frame_n = r_has_frame;
        if (wr_frame_done) begin
            w_wr_n        = r_rdy_idx;
            w_rdy_mid     = r_wr_idx;
            w_fresh_mid   = 1'b1;
            w_has_frame_n = 1'b1;
        end

        w_take    = rd_frame_start && w_fresh_mid && w_has_frame_n && !freeze;
        w_rd_n    = r_rd_idx;
        w_rdy_n   = w_rdy_mid;
        w_fresh_n = w_fresh_mid;
        if (w_take) begin
            w_rd_n    = w_rdy_mid;
            w_rdy_n   = r_rd_idx;
            w_fresh_n = 1'b0;
        end

        w_drop_inc = wr_frame_done && r_fresh;
        w_rep_inc  = rd_frame_start && !w_take && r_rd_valid && !freeze;
    end

    always_ff @(posedge clk_100Mhz) begin
        if (!sys_rst_n) begin
            r_wr_idx    <= 2'd0;
            r_rdy_idx   <= 2'd1;
            r_rd_idx    <= 2'd2;
            r_fresh     <= 1'b0;
            r_has_frame <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_wr_base   <= ADDR0;
            r_rd_base   <= ADDR2;
        end else begin
            r_wr_idx    <= w_wr_n;
            r_rdy_idx   <= w_rdy_n;
            r_rd_idx    <= w_rd_n;
            r_fresh     <= w_fresh_n;
            r_has_frame <= w_has_frame_n;
            r_rd_valid  <= r_rd_valid || w_take;
            r_wr_base   <= addr_of(w_wr_n);
            r_rd_base   <= addr_of(w_rd_n);
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk     (clk_100Mhz),
        .i_clr_n (sys_rst_n),
        .i_inc   (w_drop_inc),
        .o_cnt   (frames_dropped)
    );

    sat_counter #(.CNT_W(CNT_W)) u_rep_cnt (
        .clk     (clk_100Mhz),
        .i_clr_n (sys_rst_n),
        .i_inc   (w_rep_inc),
        .o_cnt   (frames_repeated)
    );

    assign wr_base_addr   = r_wr_base;
    assign rd_base_addr   = r_rd_base;
    assign rd_frame_valid = r_rd_valid;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Bench for frame_buffer_scheduler: a role-based buffer model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_frame_buffer_scheduler;

    localparam int          CNT_W = 3;
    localparam int          CMAX  = (1 << CNT_W) - 1;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [31:0] FRM   = 32'h0009_6000;
    localparam logic [31:0] A0    = 32'h1000_0000;
    localparam logic [31:0] A1    = 32'h1009_6000;
    localparam logic [31:0] A2    = 32'h1012_C000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_done = 1'b0;
    logic             rd_start = 1'b0;
    logic             frz = 1'b0;
    logic [31:0]      wr_base, rd_base;
    logic             rd_valid;
    logic [CNT_W-1:0] dropped, repeated;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frame_buffer_scheduler #(.BASE_ADDR(BASE), .FRAME_BYTES(FRM), .CNT_W(CNT_W)) dut (
        .clk_100Mhz      (clk),
        .sys_rst_n       (rst_n),
        .wr_frame_done   (wr_done),
        .rd_frame_start  (rd_start),
        .freeze          (frz),
        .wr_base_addr    (wr_base),
        .rd_base_addr    (rd_base),
        .rd_frame_valid  (rd_valid),
        .frames_dropped  (dropped),
        .frames_repeated (repeated)
    );

    // Model: each role names the buffer number it currently owns.
    int m_wr, m_rdy, m_rd, m_drop, m_rep, tmp;
    bit m_fresh, m_valid, cmp_en = 0;

    always @(posedge clk) begin
        cmp_en = 1;
        if (!rst_n) begin
            m_wr = 0; m_rdy = 1; m_rd = 2;
            m_fresh = 0; m_valid = 0; m_drop = 0; m_rep = 0;
        end else begin
            if (wr_done) begin
                if (m_fresh && m_drop < CMAX) m_drop++;
                tmp = m_wr; m_wr = m_rdy; m_rdy = tmp;
                m_fresh = 1;
            end
            if (rd_start) begin
                if (m_fresh && !frz) begin
                    tmp = m_rd; m_rd = m_rdy; m_rdy = tmp;
                    m_fresh = 0;
                    m_valid = 1;
                end else if (m_valid && !frz && m_rep < CMAX) begin
                    m_rep++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_wr_base", wr_base, BASE + FRM * m_wr);
            chk("model_rd_base", rd_base, BASE + FRM * m_rd);
            chk("model_valid", {31'd0, rd_valid}, {31'd0, m_valid});
            chk("model_dropped", {29'd0, dropped}, m_drop);
            chk("model_repeated", {29'd0, repeated}, m_rep);
            checks++;
            if (wr_base === rd_base) begin
                errors++;
                $display("FAIL wr_ne_rd: both %h at %0t", wr_base, $time);
            end
        end
    end

    // One cycle of stimulus; returns #1 after the edge that consumed it.
    task automatic cyc(input logic w, input logic r);
        wr_done = w; rd_start = r;
        @(posedge clk); #1;
        wr_done = 0; rd_start = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle(2);
        rst_n = 1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] w, input logic [31:0] r,
                           input logic v, input int d, input int p);
        chk({tag, "_wr_base"}, wr_base, w);
        chk({tag, "_rd_base"}, rd_base, r);
        chk({tag, "_valid"}, {31'd0, rd_valid}, {31'd0, v});
        chk({tag, "_dropped"}, {29'd0, dropped}, d);
        chk({tag, "_repeated"}, {29'd0, repeated}, p);
    endtask

    initial begin
        do_reset();
        idle(3);
        chk_all("reset", A0, A2, 0, 0, 0);

        cyc(1, 0);
        chk("one_write_wr_base", wr_base, A1);
        idle(9);
        cyc(0, 1);
        chk_all("first_read", A1, A0, 1, 0, 0);

        cyc(1, 0); cyc(1, 0); cyc(1, 0);
        chk_all("three_writes", A2, A0, 1, 2, 0);

        cyc(0, 1);
        chk("take_rd_base", rd_base, A1);
        cyc(0, 1); idle(2); cyc(0, 1);
        chk_all("repeats", A2, A1, 1, 2, 2);

        cyc(1, 1);
        chk_all("simul", A0, A2, 1, 2, 2);
        cyc(0, 1);
        chk_all("simul_no_fresh", A0, A2, 1, 2, 3);

        do_reset();
        frz = 1;
        cyc(1, 0); cyc(0, 1); cyc(1, 0); cyc(1, 0); cyc(0, 1);
        cyc(1, 0); cyc(0, 1); cyc(1, 0);
        idle(2);
        frz = 0;
        chk_all("freeze", A1, A2, 0, 4, 0);
        cyc(0, 1);
        chk_all("unfreeze", A1, A0, 1, 4, 0);

        cyc(1, 0); cyc(1, 0);
        rst_n = 0;
        cyc(1, 1);
        chk_all("mid_reset", A0, A2, 0, 0, 0);
        rst_n = 1;
        idle(1);

        for (int i = 0; i < 10; i++) cyc(1, 0);
        chk("sat_dropped", {29'd0, dropped}, CMAX);
        cyc(0, 1);
        for (int i = 0; i < 10; i++) cyc(0, 1);
        chk("sat_repeated", {29'd0, repeated}, CMAX);
        chk("sat_dropped_hold", {29'd0, dropped}, CMAX);

        for (int i = 0; i < 40; i++) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        frz = 1;
        for (int i = 0; i < 20; i++) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        frz = 0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
